// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM state encoding and default operand width for serial arithmetic blocks.
package serial_arith_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_sub_bit_cell.sv
// sub_bit_cell: combinational full-subtractor bit cell, d = x - y - bi with borrow-out bo.
module sub_bit_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor (A - B - Bin, LSB first) with valid/ready on both sides.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH:0]   res_sh;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, d, bo, accept, shift, last;
  sub_bit_cell u_cell (.x(a_q[0]), .y(b_q[0]), .bi(brw_q), .d(d), .bo(bo));
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign accept    = in_valid & in_ready;
  assign shift     = state_q == SHIFT;
  assign last      = cnt_q == CW'(WIDTH - 1);
  assign res_sh    = {d, res_q} >> 1;
  // Gated so that an in-flight partial result never reaches the consumer.
  assign diff      = out_valid ? res_q : '0;
  assign bout      = out_valid & brw_q;
  always_comb begin
    a_d     = accept ? a : shift ? a_q >> 1 : a_q;
    b_d     = accept ? b : shift ? b_q >> 1 : b_q;
    brw_d   = accept ? bin : shift ? bo : brw_q;
    cnt_d   = accept ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
    res_d   = shift ? res_sh[WIDTH-1:0] : res_q;
    state_d = accept ? SHIFT : (shift && last) ? DONE : (out_valid && out_ready) ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
  // On the final edge the cell sees the operand MSBs and produces the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (accept) ovf_q <= 1'b0;
    else if (shift && last) ovf_q <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ d);
  end
  assign ovf = out_valid & ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed plus randomized checks of serial_sub against an arithmetic reference model.
module tb_serial_sub;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, bin = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, bout;
  logic [W-1:0] diff;
  int           n_cmp = 0, n_err = 0;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
`endif
  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Runs one operation; hold = cycles of backpressure after out_valid rises.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in, input int hold);
    int n, total, sr;
    logic [W-1:0] ed, held;
    logic eb;
    total = int'(av) - int'(bv) - int'(bv_in);
    ed = total[W-1:0];
    eb = total < 0;
    sr = int'($signed(av)) - int'($signed(bv)) - int'(bv_in);
    check("accept_ready", in_ready, 1);
    a = av; b = bv; bin = bv_in; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    // Busy-time operand traffic must be ignored.
    in_valid = $urandom_range(0, 1); a = $urandom; b = $urandom; bin = $urandom_range(0, 1);
    check("busy_ready", in_ready, 0);
    n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("latency", n, W + 1);
    check("diff", diff, ed);
    check("bout", bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", ovf, (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1));
`endif
    held = diff;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_diff", diff, held);
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
  endtask

  initial begin
    #12;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h5A, 8'h3C, 1'b0, 0);
    do_op(8'h00, 8'h01, 1'b0, 0);
    do_op(8'h10, 8'h0F, 1'b1, 0);
    do_op(8'h05, 8'h03, 1'b0, 5);
    do_op(8'h80, 8'h01, 1'b0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 0);
    do_op(8'h00, 8'hFF, 1'b1, 1);
    // Abort mid-operation.
    a = 8'hFF; b = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_diff", diff, 0);
    check("abort_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h09, 8'h04, 1'b0, 0);
    for (int k = 0; k < 25; k++)
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
